// File: rtl/cpu6502_pkg.sv
// Shared 6502/2A03 definitions: status-register bit positions and the
// power-on flag image.
package cpu6502_pkg;

  localparam int P_C = 0;
  localparam int P_Z = 1;
  localparam int P_I = 2;
  localparam int P_D = 3;
  localparam int P_B = 4;
  localparam int P_U = 5;
  localparam int P_V = 6;
  localparam int P_N = 7;

  localparam logic [7:0] P_RESET = 8'h04;

endpackage

// File: rtl/p_flag_cell.sv
// One status flag flop: async reset value, phase enable, and a four-entry
// load list where entry 0 has the highest priority.
module p_flag_cell #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_ce,
  input  logic [3:0] i_sel,
  input  logic [3:0] i_val,
  output logic       o_q
);

  logic r_q;
  logic w_next;

  always_comb begin
    w_next = r_q;
    if (i_sel[0])      w_next = i_val[0];
    else if (i_sel[1]) w_next = i_val[1];
    else if (i_sel[2]) w_next = i_val[2];
    else if (i_sel[3]) w_next = i_val[3];
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      r_q <= RESET_VAL;
    else if (i_ce)
      r_q <= w_next;
  end

  assign o_q = r_q;

endmodule

// File: rtl/processor_status_reg.sv
// 6502/2A03 processor status register: six stored flags, a push-time B/bit-5
// view, an optionally instruction-delayed IRQ mask and decimal suppression.
module processor_status_reg
  import cpu6502_pkg::*;
#(
  parameter logic [7:0] RESET_P        = P_RESET,
  parameter bit         DECIMAL_EN     = 1'b0,
  parameter bit         IRQ_MASK_DELAY = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_ce,
  input  logic [7:0] i_db,
  input  logic       i_ir5,
  input  logic       i_acr,
  input  logic       i_avr,
  input  logic       i_db_p,
  input  logic       i_db0_c,
  input  logic       i_ir5_c,
  input  logic       i_acr_c,
  input  logic       i_db1_z,
  input  logic       i_dbz_z,
  input  logic       i_db2_i,
  input  logic       i_ir5_i,
  input  logic       i_set_i,
  input  logic       i_db3_d,
  input  logic       i_ir5_d,
  input  logic       i_db6_v,
  input  logic       i_avr_v,
  input  logic       i_clr_v,
  input  logic       i_db7_n,
  input  logic       i_sync,
  input  logic       i_brk_push,
  output logic [7:0] o_p,
  output logic       o_irq_mask,
  output logic       o_decimal
);

  logic w_c, w_z, w_i, w_d, w_v, w_n;
  logic w_dbz;

  assign w_dbz = ~|i_db;

  p_flag_cell #(.RESET_VAL(RESET_P[P_C])) u_c (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_ce(i_ce),
    .i_sel({i_ir5_c, i_acr_c, i_db0_c, i_db_p}),
    .i_val({i_ir5, i_acr, i_db[0], i_db[0]}),
    .o_q(w_c)
  );

  p_flag_cell #(.RESET_VAL(RESET_P[P_Z])) u_z (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_ce(i_ce),
    .i_sel({1'b0, i_dbz_z, i_db1_z, i_db_p}),
    .i_val({1'b0, w_dbz, i_db[1], i_db[1]}),
    .o_q(w_z)
  );

  // Interrupt entry forces I above every other source, including PLP/RTI.
  p_flag_cell #(.RESET_VAL(RESET_P[P_I])) u_i (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_ce(i_ce),
    .i_sel({i_ir5_i, i_db2_i, i_db_p, i_set_i}),
    .i_val({i_ir5, i_db[2], i_db[2], 1'b1}),
    .o_q(w_i)
  );

  p_flag_cell #(.RESET_VAL(RESET_P[P_D])) u_d (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_ce(i_ce),
    .i_sel({1'b0, i_ir5_d, i_db3_d, i_db_p}),
    .i_val({1'b0, i_ir5, i_db[3], i_db[3]}),
    .o_q(w_d)
  );

  p_flag_cell #(.RESET_VAL(RESET_P[P_V])) u_v (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_ce(i_ce),
    .i_sel({i_clr_v, i_avr_v, i_db6_v, i_db_p}),
    .i_val({1'b0, i_avr, i_db[6], i_db[6]}),
    .o_q(w_v)
  );

  p_flag_cell #(.RESET_VAL(RESET_P[P_N])) u_n (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_ce(i_ce),
    .i_sel({2'b00, i_db7_n, i_db_p}),
    .i_val({2'b00, i_db[7], i_db[7]}),
    .o_q(w_n)
  );

  // B and bit 5 only exist in the pushed image, never in storage.
  assign o_p = {w_n, w_v, 1'b1, i_brk_push, w_d, w_i, w_z, w_c};

  assign o_decimal = w_d & DECIMAL_EN;

  generate
    if (IRQ_MASK_DELAY) begin : g_mask_delay
      logic r_irq_mask;

      // The mask picks up I as it stood before the boundary edge, so a
      // CLI/SEI/PLP is honoured one instruction later; interrupt entry is not delayed.
      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
          r_irq_mask <= RESET_P[P_I];
        else if (i_ce) begin
          if (i_set_i)
            r_irq_mask <= 1'b1;
          else if (i_sync)
            r_irq_mask <= w_i;
        end
      end

      assign o_irq_mask = r_irq_mask;
    end else begin : g_mask_direct
      assign o_irq_mask = w_i;
    end
  endgenerate

endmodule

// File: tb/tb_processor_status_reg.sv
// Directed checks of processor_status_reg at default parameters
// (RESET_P=8'h04, DECIMAL_EN=0, IRQ_MASK_DELAY=1).
module tb_processor_status_reg;

  logic       i_clk = 1'b0;
  logic       i_reset_n;
  logic       i_ce;
  logic [7:0] i_db;
  logic       i_ir5, i_acr, i_avr;
  logic       i_db_p, i_db0_c, i_ir5_c, i_acr_c;
  logic       i_db1_z, i_dbz_z;
  logic       i_db2_i, i_ir5_i, i_set_i;
  logic       i_db3_d, i_ir5_d;
  logic       i_db6_v, i_avr_v, i_clr_v;
  logic       i_db7_n;
  logic       i_sync, i_brk_push;
  logic [7:0] o_p;
  logic       o_irq_mask, o_decimal;

  int total = 0;
  int bad   = 0;

  processor_status_reg dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_ce(i_ce), .i_db(i_db),
    .i_ir5(i_ir5), .i_acr(i_acr), .i_avr(i_avr),
    .i_db_p(i_db_p), .i_db0_c(i_db0_c), .i_ir5_c(i_ir5_c), .i_acr_c(i_acr_c),
    .i_db1_z(i_db1_z), .i_dbz_z(i_dbz_z),
    .i_db2_i(i_db2_i), .i_ir5_i(i_ir5_i), .i_set_i(i_set_i),
    .i_db3_d(i_db3_d), .i_ir5_d(i_ir5_d),
    .i_db6_v(i_db6_v), .i_avr_v(i_avr_v), .i_clr_v(i_clr_v),
    .i_db7_n(i_db7_n), .i_sync(i_sync), .i_brk_push(i_brk_push),
    .o_p(o_p), .o_irq_mask(o_irq_mask), .o_decimal(o_decimal)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%02h expected=%02h", tag, got, exp);
    end
  endtask

  task automatic clear_sel();
    i_db_p = 0; i_db0_c = 0; i_ir5_c = 0; i_acr_c = 0;
    i_db1_z = 0; i_dbz_z = 0;
    i_db2_i = 0; i_ir5_i = 0; i_set_i = 0;
    i_db3_d = 0; i_ir5_d = 0;
    i_db6_v = 0; i_avr_v = 0; i_clr_v = 0;
    i_db7_n = 0; i_sync = 0;
  endtask

  // one clock; inputs are sampled at the edge, outputs checked 1ns later
  task automatic tick();
    @(posedge i_clk);
    #1;
    clear_sel();
  endtask

  initial begin
    i_reset_n = 0; i_ce = 1; i_db = 8'h00;
    i_ir5 = 0; i_acr = 0; i_avr = 0; i_brk_push = 0;
    clear_sel();
    tick(); tick();
    i_reset_n = 1;
    tick();

    check("reset_p", o_p, 8'h24);
    i_brk_push = 1; #1;
    check("reset_p_brk", o_p, 8'h34);
    i_brk_push = 0; #1;
    check("reset_mask", {7'd0, o_irq_mask}, 8'h01);
    check("reset_dec", {7'd0, o_decimal}, 8'h00);

    // Z from zero bus, first with the phase enable low
    i_db = 8'h00; i_dbz_z = 1; i_ce = 0;
    tick();
    check("dbz_ce0", o_p, 8'h24);
    i_ce = 1; i_db = 8'h00; i_dbz_z = 1;
    tick();
    check("dbz_z", o_p, 8'h26);

    // PLP-style full load
    i_db = 8'hCB; i_db_p = 1;
    tick();
    check("db_p", o_p, 8'hEB);
    check("dec_supp", {7'd0, o_decimal}, 8'h00);
    check("mask_no_sync", {7'd0, o_irq_mask}, 8'h01);

    // C: clear via ALU, then db0 beats acr on the same edge
    i_acr = 0; i_acr_c = 1;
    tick();
    check("c_acr", o_p, 8'hEA);
    i_db = 8'h01; i_db0_c = 1; i_acr = 0; i_acr_c = 1;
    tick();
    check("c_db0_wins", o_p, 8'hEB);

    // V: CLV alone, then avr beats clr_v
    i_clr_v = 1;
    tick();
    check("v_clr", o_p, 8'hAB);
    i_avr = 1; i_avr_v = 1; i_clr_v = 1;
    tick();
    check("v_avr_wins", o_p, 8'hEB);

    // SEI, boundary, CLI, boundary
    i_ir5 = 1; i_ir5_i = 1;
    tick();
    check("sei_p", o_p, 8'hEF);
    check("sei_mask", {7'd0, o_irq_mask}, 8'h01);
    i_sync = 1;
    tick();
    check("sync1_mask", {7'd0, o_irq_mask}, 8'h01);
    i_ir5 = 0; i_ir5_i = 1;
    tick();
    check("cli_p", o_p, 8'hEB);
    check("cli_mask_held", {7'd0, o_irq_mask}, 8'h01);
    i_sync = 1;
    tick();
    check("cli_mask_sync", {7'd0, o_irq_mask}, 8'h00);
    i_set_i = 1;
    tick();
    check("set_i_p", o_p, 8'hEF);
    check("set_i_mask", {7'd0, o_irq_mask}, 8'h01);

    // sync and CLI together: mask takes the old I
    i_sync = 1; i_ir5 = 0; i_ir5_i = 1;
    tick();
    check("sync_cli_p", o_p, 8'hEB);
    check("sync_cli_mask", {7'd0, o_irq_mask}, 8'h01);
    i_sync = 1;
    tick();
    check("sync_mask0", {7'd0, o_irq_mask}, 8'h00);
    // set_i beats sync when I was clear; also beats db_p with bit 2 low
    i_sync = 1; i_set_i = 1; i_db_p = 1; i_db = 8'hCB;
    tick();
    check("set_i_wins_p", o_p, 8'hEF);
    check("set_i_wins_mask", {7'd0, o_irq_mask}, 8'h01);

    // N, D, Z individual loads
    i_db = 8'h00; i_db7_n = 1;
    tick();
    check("n_db7", o_p, 8'h6F);
    i_ir5 = 0; i_ir5_d = 1;
    tick();
    check("d_ir5", o_p, 8'h67);
    i_db = 8'h00; i_db1_z = 1;
    tick();
    check("z_db1", o_p, 8'h65);

    // reset mid-cycle drops a pending load and acts immediately
    i_db = 8'hCB; i_db_p = 1;
    #2;
    i_reset_n = 0;
    #1;
    check("async_rst_p", o_p, 8'h24);
    check("async_rst_mask", {7'd0, o_irq_mask}, 8'h01);
    @(posedge i_clk); #1;
    i_reset_n = 1;
    clear_sel();
    tick();
    check("post_rst_p", o_p, 8'h24);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/processor_status_reg.md
Name: processor_status_reg

Overview:
- Full 6502/2A03 processor status register (P): stores C, Z, I, D, V, N under individual control-line loads from the data bus, ALU and IR5.
- Supersedes the Z/N-only status block.
- Adds clocked phase-enabled operation, a parametrised reset image and decimal-mode suppression for the 2A03.
- Adds a push-time B/bit-5 view and an instruction-boundary-delayed IRQ mask.
- Sits beside the ALU; P output feeds branch logic, the stack-push mux and the interrupt controller.

Parameters:
- RESET_P, 8'h04, flag image loaded on reset; bits 4 and 5 ignored; default I=1, others 0.
- DECIMAL_EN, 0, when 0 D is stored and readable but o_decimal is forced 0 (2A03 behaviour).
- IRQ_MASK_DELAY, 1, when 1 o_irq_mask tracks I only at instruction boundaries; when 0 o_irq_mask = I combinationally.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_ce  in  1  phase enable; all state updates require i_ce=1.
- i_db  in  8  internal data bus.
- i_ir5  in  1  IR bit 5 (set/clear value for SEC/CLC/SEI/CLI/SED/CLD).
- i_acr  in  1  ALU carry out.
- i_avr  in  1  ALU overflow out.
- i_db_p  in  1  load C,Z,I,D,V,N from i_db bits 0,1,2,3,6,7 (PLP/RTI).
- i_db0_c, i_ir5_c, i_acr_c  in  1 each  C load selects.
- i_db1_z, i_dbz_z  in  1 each  Z load selects (bit 1 / bus-is-zero).
- i_db2_i, i_ir5_i, i_set_i  in  1 each  I load selects; i_set_i forces I=1 (interrupt entry).
- i_db3_d, i_ir5_d  in  1 each  D load selects.
- i_db6_v, i_avr_v, i_clr_v  in  1 each  V load selects; i_clr_v forces V=0 (CLV).
- i_db7_n  in  1  N load from i_db[7].
- i_sync  in  1  instruction-boundary strobe (opcode fetch cycle).
- i_brk_push  in  1  1 when pushing for BRK/PHP, 0 for IRQ/NMI.
- o_p  out  8  {N,V,1,i_brk_push,D,I,Z,C}; bits 5 and 4 combinational.
- o_irq_mask  out  1  I value the interrupt controller honours.
- o_decimal  out  1  D & DECIMAL_EN.

Behaviour:
- Reset (async, i_reset_n=0): C,Z,I,D,V,N take the RESET_P bits.
  - o_irq_mask takes RESET_P[2].
  - Reset dominates all selects and i_ce.
  - Reset asserted mid-instruction discards any pending load.
- Update on rising i_clk only when i_ce=1; with i_ce=0 every flag and the mask hold.
- Each flag updates independently; a flag with no select active holds.
- Priority when several selects hit one flag in the same cycle (highest first):
  - C: i_db_p, i_db0_c, i_acr_c, i_ir5_c.
  - Z: i_db_p, i_db1_z, i_dbz_z.
  - I: i_set_i, i_db_p, i_db2_i, i_ir5_i.
  - D: i_db_p, i_db3_d, i_ir5_d.
  - V: i_db_p, i_db6_v, i_avr_v, i_clr_v.
  - N: i_db_p, i_db7_n.
- Z via i_dbz_z = NOR of all 8 i_db bits, sampled the same edge.
- Latency: flag visible on o_p one clock after the enabled edge; there is no bypass.
- Pushed image: o_p[5]=1 always; o_p[4]=i_brk_push (combinational, no storage). The B bit never exists in the register.
- IRQ mask with IRQ_MASK_DELAY=1:
  - On an enabled edge with i_sync=1, o_irq_mask <= I (the pre-edge I value). A CLI/SEI/PLP therefore takes effect one instruction later.
  - i_set_i sets I and o_irq_mask to 1 on the same edge, with no delay.
  - Simultaneous i_sync and I-load: mask samples the old I; i_set_i still wins and sets the mask to 1.
- IRQ mask with IRQ_MASK_DELAY=0: o_irq_mask = I.
- Decimal suppression: with DECIMAL_EN=0, D is still stored and pushed via o_p[3] exactly as loaded; only o_decimal is forced 0.

Decomposition:
- Shared package cpu6502_pkg holds the flag bit indices: C=0, Z=1, I=2, D=3, B=4, U=5, V=6, N=7.
- The same package holds the default reset image P_RESET=8'h04.
- One natural sub-module, p_flag_cell: a single flag flop with async reset value, i_ce, and a 4-way priority-ordered load list. It is instantiated six times.

Test Plan:
- Reset with RESET_P=8'h04, then release:
  - o_p=8'h24 with i_brk_push=0; o_p=8'h34 with i_brk_push=1.
  - o_irq_mask=1, o_decimal=0.
- i_db=8'h00 with i_dbz_z=1 and i_ce=1 -> Z=1, o_p[1]=1 next cycle. The same stimulus with i_ce=0 -> Z unchanged.
- i_db=8'hCB with i_db_p=1 -> o_p=8'hEB (brk=0, pushed image 8'hEB).
- i_db=8'hCB with i_db_p=1 and DECIMAL_EN=0 -> o_decimal=0 while o_p[3]=1.
- Same-edge conflict, i_acr=0 with i_acr_c=1, i_db[0]=1 with i_db0_c=1 -> C=1 (db0 wins).
- Same-edge conflict, i_clr_v with i_avr_v and i_avr=1 -> V=1.
- CLI (i_ir5=0, i_ir5_i=1) followed by i_sync:
  - The mask stays 1 on the CLI edge.
  - The mask goes 0 only at the next i_sync edge.
  - Then i_set_i -> I=1 and mask=1 on the same edge.
- Reset asserted between two enabled edges with i_db_p pending -> the load is lost and all flags equal RESET_P immediately (asynchronous).
